// File: rtl/gin_multicast.sv
// ----------------------------------------------------------------------------
// gin_multicast
//   Global input network for one data type (ifmap, filter or ipsum). Accepts
//   tagged words from the PE-array controller, holds one word in a single
//   entry, and multicasts it to every PE whose scanned-in (XID, YID) matches
//   the (tag_X, tag_Y) it arrived with. The entry frees once every targeted
//   PE has completed its own handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   set_XID, XID_scan_in  shift one value into the per-PE XID chain
//   set_YID, YID_scan_in  shift one value into the per-row YID chain
//   tag_X, tag_Y          destination tag, qualified by GLB_valid
//   GLB_valid, GLB_ready  controller-side handshake (GLB_ready combinational)
//   data_in               payload from the controller
//   PE_ready              per-PE ready, bit i = PE(row i/COL, col i%COL)
//   PE_valid              per-PE valid
//   PE_data               buffered payload, broadcast to all PEs
// ----------------------------------------------------------------------------
module gin_multicast #(
   parameter int unsigned NUMS_PE_ROW = 6,
   parameter int unsigned NUMS_PE_COL = 8,
   parameter int unsigned XID_BITS    = 5,
   parameter int unsigned YID_BITS    = 3,
   parameter int unsigned DATA_BITS   = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               set_XID,
   input  logic [XID_BITS-1:0]                XID_scan_in,
   input  logic                               set_YID,
   input  logic [YID_BITS-1:0]                YID_scan_in,
   input  logic [XID_BITS-1:0]                tag_X,
   input  logic [YID_BITS-1:0]                tag_Y,
   input  logic                               GLB_valid,
   output logic                               GLB_ready,
   input  logic [DATA_BITS-1:0]               data_in,
   input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_ready,
   output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_valid,
   output logic [DATA_BITS-1:0]               PE_data
);

   localparam int unsigned N = NUMS_PE_ROW * NUMS_PE_COL;

   // ------------------------------------------------------------------------
   // ID scan chains
   // ------------------------------------------------------------------------
   logic [XID_BITS-1:0] xid_q [N];
   logic [XID_BITS-1:0] xid_d [N];
   logic [YID_BITS-1:0] yid_q [NUMS_PE_ROW];
   logic [YID_BITS-1:0] yid_d [NUMS_PE_ROW];

   // Shift toward index 0; new value enters at the top so that after a full
   // pass the value shifted on step j lands in entry j.
   always_comb begin
      xid_d = xid_q;
      if (set_XID) begin
         for (int unsigned k = 0; k < N - 1; k++) begin
            xid_d[k] = xid_q[k+1];
         end
         xid_d[N-1] = XID_scan_in;
      end
   end

   always_comb begin
      yid_d = yid_q;
      if (set_YID) begin
         for (int unsigned k = 0; k < NUMS_PE_ROW - 1; k++) begin
            yid_d[k] = yid_q[k+1];
         end
         yid_d[NUMS_PE_ROW-1] = YID_scan_in;
      end
   end

   // ID chain registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < N; k++) begin
            xid_q[k] <= '0;
         end
         for (int unsigned k = 0; k < NUMS_PE_ROW; k++) begin
            yid_q[k] <= '0;
         end
      end else begin
         xid_q <= xid_d;
         yid_q <= yid_d;
      end
   end

   // ------------------------------------------------------------------------
   // Tag match against the current (pre-shift) IDs
   // ------------------------------------------------------------------------
   logic [N-1:0] match_c;

   for (genvar gi = 0; gi < N; gi++) begin : g_match
      localparam int unsigned ROW = gi / NUMS_PE_COL;
      assign match_c[gi] = (xid_q[gi] == tag_X) && (yid_q[ROW] == tag_Y);
   end

   // ------------------------------------------------------------------------
   // Single buffer entry
   // ------------------------------------------------------------------------
   logic                 full_q, full_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [N-1:0]         mask_q, mask_d;
   logic [N-1:0]         done_q, done_d;

   logic [N-1:0]         hs_c;
   logic                 finish_c;
   logic                 accept_c;

   assign PE_valid  = {N{full_q}} & mask_q & ~done_q;
   assign PE_data   = data_q;
   assign hs_c      = PE_valid & PE_ready;

   // Entry is finished when every targeted PE is done or handshakes now;
   // an empty mask therefore finishes in its first full cycle.
   assign finish_c  = full_q & ~(|(mask_q & ~(done_q | hs_c)));
   assign GLB_ready = ~full_q | finish_c;
   assign accept_c  = GLB_valid & GLB_ready;

   // Entry next state: accept overrides free so a finish cycle reloads.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      mask_d = mask_q;
      done_d = done_q | hs_c;
      if (accept_c) begin
         full_d = 1'b1;
         data_d = data_in;
         mask_d = match_c;
         done_d = '0;
      end else if (finish_c) begin
         full_d = 1'b0;
         mask_d = '0;
         done_d = '0;
      end
   end

   // Entry registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
         mask_q <= '0;
         done_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         mask_q <= mask_d;
         done_q <= done_d;
      end
   end

endmodule

// File: doc/gin_multicast.md
# gin_multicast

Global input network (GIN) for one data type (ifmap, filter or ipsum) between the PE-array controller and the PE array. It receives the controller's GLB valid/ready transfers tagged with (tag_X, tag_Y), buffers one word, and multicasts it to every PE whose scanned-in (XID, YID) matches the tag. The per-PE XIDs and per-row YIDs are loaded through the controller's set_XID/set_YID scan chains. One instance is built per data type.

## Interface
- NUMS_PE_ROW, 6, PE rows
- NUMS_PE_COL, 8, PE columns; N = NUMS_PE_ROW*NUMS_PE_COL
- XID_BITS, 5, XID/tag_X width
- YID_BITS, 3, YID/tag_Y width
- DATA_BITS, 32, payload width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- set_XID  in  1  shift XID chain this cycle
- XID_scan_in  in  XID_BITS  XID value shifted in
- set_YID  in  1  shift YID chain this cycle
- YID_scan_in  in  YID_BITS  YID value shifted in
- tag_X  in  XID_BITS  destination X tag, qualified by GLB_valid
- tag_Y  in  YID_BITS  destination Y tag, qualified by GLB_valid
- GLB_valid  in  1  controller has a word
- GLB_ready  out  1  GIN accepts the word this cycle
- data_in  in  DATA_BITS  payload
- PE_ready  in  N  per-PE ready; bit i = PE (row i/NUMS_PE_COL, col i%NUMS_PE_COL)
- PE_valid  out  N  per-PE valid
- PE_data  out  DATA_BITS  buffered payload, broadcast to all PEs

## Operation
- ID chains: XID[0..N-1] and YID[0..NUMS_PE_ROW-1] registers, reset to 0.
  - set_XID: XID[N-1] <= XID_scan_in, XID[k] <= XID[k+1]. After exactly N consecutive shifts, the value scanned on shift j sits in XID[j].
  - set_YID: same scheme on YID with NUMS_PE_ROW entries. Both chains may shift in the same cycle.
  - Extra shifts keep shifting; there is no saturation.
- Buffer: a single entry {full, data, mask[N], done[N]}.
- Accept: a transfer is accepted when GLB_valid & GLB_ready.
  - Load data.
  - Load mask[i] = (XID[i]==tag_X) & (YID[i/NUMS_PE_COL]==tag_Y), using the ID register values from the same cycle (pre-shift).
  - Clear done and set full.
  - The mask is frozen at load. Scan shifts during a pending entry do not alter it.
- Delivery:
  - PE_valid[i] = full & mask[i] & ~done[i].
  - On PE_valid[i] & PE_ready[i], set done[i].
  - PEs complete independently, in any order.
- Completion: finish = full & ((mask & ~(done | (PE_ready & PE_valid))) == 0).
  - On finish the entry frees.
  - An entry with mask == 0 finishes in its first full cycle and is dropped.
- GLB_ready = ~full | finish (combinational). An accept in the finish cycle reloads the entry with no bubble.
- GLB_valid & ~GLB_ready: no effect. The controller holds the word.

## Timing
- Reset values:
  - full=0, mask=0, done=0, data=0, all IDs=0.
  - PE_valid=0, PE_data=0.
  - GLB_ready=1 after reset.
- Latency: accepted at edge T → PE_valid high in cycle T+1. PE_data is registered.
- Throughput: one word per cycle when all targeted PE_ready are held high.
- Simultaneous finish + accept: the old entry's final handshakes complete, and the new data/mask are visible the next cycle.
- Reset asserted mid-transfer: the entry is discarded immediately, PE_valid drops asynchronously, and IDs clear (the chain must be rescanned).
- PE_ready on a PE with mask=0 or done=1 is ignored.
- Widths: tag compares are exact width. PE row index = i / NUMS_PE_COL, a constant per bit.

## Test plan
- Scan: 48 set_XID cycles with XID_scan_in=j%8, then 6 set_YID cycles with YID_scan_in=j → XID[13]=5 and YID[4]=4. Send tag (5,1), data 0xA5A5_0001, all PE_ready=1 → only PE 13 sees PE_valid, for one cycle. GLB_ready stays high throughout.
- Multicast with staggered ready: 4 targets, one PE_ready each on cycles 1..4 → GLB_ready=0 on cycles 1-3 and 1 on cycle 4. The next word is accepted on cycle 4 and is valid on cycle 5.
- No match: tag (31,7) with no matching IDs → the word is dropped one cycle after accept and no PE_valid rises.
- Back-to-back stream: 10 words to a single always-ready PE → 10 consecutive PE_valid cycles with data in order and no bubbles.
- Scan during pending entry: hold the target's PE_ready=0, pulse set_XID 3 times, then release → the original target still receives the word.
- Reset mid-transfer: rst_n low while full → PE_valid=0 and GLB_ready=1 after release, and all XIDs read back 0 (tag (0,0) then hits all 48 PEs).
